// File: rtl/bp_btb_tagged_pkg.sv
// Shared BTB definitions: default geometry and saturating-counter encodings.
package bp_btb_tagged_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned DEF_ENTRIES = 64;
  localparam int unsigned DEF_TAG_W   = 8;
  localparam int unsigned DEF_CTR_W   = 2;

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic int unsigned ctr_weak_taken(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  // Weakly-not-taken: one below weakly-taken.
  function automatic int unsigned ctr_weak_not_taken(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_btb_tagged_if.sv
// Lookup / prediction / update / flush signal bundle between fetch, EX and the BTB.
interface bp_btb_tagged_if;
  import bp_btb_tagged_pkg::*;

  logic            lk_valid;
  logic [PC_W-1:0] lk_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            flush_all;

  modport master (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_all,
    input  pred_valid, pred_taken, pred_target
  );

  modport slave (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_all,
    output pred_valid, pred_taken, pred_target
  );
endinterface

// File: rtl/bp_satctr.sv
// Saturating up/down direction counter next-state.
module bp_satctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next_c
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    ctr_next_c = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next_c = ctr + CTR_W'(1);
    end else if (ctr != '0) begin
      ctr_next_c = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/bp_btb_tagged.sv
// Direct-mapped tagged BTB with 2-bit-style direction counters and same-edge update bypass.
module bp_btb_tagged
  import bp_btb_tagged_pkg::*;
#(
  parameter int unsigned ENTRIES = DEF_ENTRIES,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned CTR_W   = DEF_CTR_W
) (
  input logic             clk,
  input logic             rst_n,
  bp_btb_tagged_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

  logic             valid_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_live, up_hit, byp;
  logic [CTR_W-1:0] up_ctr_next, byp_ctr_next;

  logic             e_valid;
  logic [TAG_W-1:0] e_tag;
  logic [PC_W-1:0]  e_tgt;
  logic [CTR_W-1:0] e_ctr;
  logic             taken_d;
  logic [PC_W-1:0]  target_d;

  logic unused_pc;
  assign unused_pc = ^{bus.lk_pc, bus.upd_pc};

  assign lk_idx  = bus.lk_pc[IDX_W+1:2];
  assign lk_tag  = bus.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx  = bus.upd_pc[IDX_W+1:2];
  assign up_tag  = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_live = bus.upd_valid && !bus.flush_all;
  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign byp     = up_live && (up_idx == lk_idx);

  bp_satctr #(.CTR_W(CTR_W)) u_ctr_upd (
    .ctr(ctr_q[up_idx]), .taken(bus.upd_taken), .ctr_next_c(up_ctr_next)
  );

  bp_satctr #(.CTR_W(CTR_W)) u_ctr_byp (
    .ctr(ctr_q[lk_idx]), .taken(bus.upd_taken), .ctr_next_c(byp_ctr_next)
  );

  // Entry as the lookup sees it: stored state, or the post-update state when bypassing.
  always_comb begin
    e_valid = valid_q[lk_idx];
    e_tag   = tag_q[lk_idx];
    e_tgt   = tgt_q[lk_idx];
    e_ctr   = ctr_q[lk_idx];
    if (byp) begin
      if (up_hit) begin
        e_ctr = byp_ctr_next;
        if (bus.upd_taken) e_tgt = bus.upd_target;
      end else if (bus.upd_taken) begin
        e_valid = 1'b1;
        e_tag   = up_tag;
        e_tgt   = bus.upd_target;
        e_ctr   = CTR_WT;
      end
    end
    taken_d  = bus.lk_valid && !bus.flush_all && e_valid && (e_tag == lk_tag) && e_ctr[CTR_W-1];
    target_d = taken_d ? e_tgt : bus.lk_pc + PC_W'(4);
  end

  // Valid bits and counters: reset and flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (bus.flush_all) begin
      for (int unsigned i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_next;
      end else if (bus.upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WT;
      end
    end
  end

  // Tags and targets are unreset; any taken update writes both (tag unchanged on a hit).
  always_ff @(posedge clk) begin
    if (up_live && bus.upd_taken) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= bus.upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pred_valid  <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
    end else begin
      bus.pred_valid  <= bus.lk_valid;
      bus.pred_taken  <= taken_d;
      bus.pred_target <= target_d;
    end
  end

endmodule

// File: tb/tb_bp_btb_tagged.sv
// Directed self-checking bench for bp_btb_tagged (default geometry: 64 entries, 8-bit tag, 2-bit counter).
module tb_bp_btb_tagged;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  bp_btb_tagged_if bus ();

  bp_btb_tagged dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.lk_valid  = 1'b0;
    bus.upd_valid = 1'b0;
    bus.flush_all = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    idle();
    bus.lk_valid = 1'b1;
    bus.lk_pc    = pc;
    step();
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    idle();
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
    step();
  endtask

  task automatic pred(input string tag, input logic tk, input logic [31:0] tgt);
    check({tag, ".valid"},  32'(bus.pred_valid), 32'd1);
    check({tag, ".taken"},  32'(bus.pred_taken), 32'(tk));
    check({tag, ".target"}, bus.pred_target, tgt);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.lk_valid   = 1'b0;
    bus.lk_pc      = 32'h0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = 32'h0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = 32'h0;
    bus.flush_all  = 1'b0;
    #3;
    check("rst.valid",  32'(bus.pred_valid), 32'd0);
    check("rst.taken",  32'(bus.pred_taken), 32'd0);
    check("rst.target", bus.pred_target, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Cold lookup misses with fall-through target
    lookup(32'h0000_1000);
    pred("cold", 1'b0, 32'h0000_1004);
    idle();
    step();
    check("idle.valid", 32'(bus.pred_valid), 32'd0);

    // Allocate, hit, alias on same index with a different tag, low PC bits ignored
    update(32'h0000_1000, 1'b1, 32'h0000_2000);
    lookup(32'h0000_1000);
    pred("alloc_hit", 1'b1, 32'h0000_2000);
    lookup(32'h0000_1100);
    pred("alias_miss", 1'b0, 32'h0000_1104);
    lookup(32'h0000_1002);
    pred("lowbits_hit", 1'b1, 32'h0000_2000);

    // Counter walk from 2: down, floor, up, ceiling, down
    update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    lookup(32'h0000_1000);
    pred("ctr0", 1'b0, 32'h0000_1004);
    update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    update(32'h0000_1000, 1'b1, 32'h0000_2400);
    lookup(32'h0000_1000);
    pred("floor_ctr1", 1'b0, 32'h0000_1004);
    update(32'h0000_1000, 1'b1, 32'h0000_2400);
    lookup(32'h0000_1000);
    pred("ctr2", 1'b1, 32'h0000_2400);
    update(32'h0000_1000, 1'b1, 32'h0000_2400);
    update(32'h0000_1000, 1'b1, 32'h0000_2400);
    update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    lookup(32'h0000_1000);
    pred("ceil_ctr2", 1'b1, 32'h0000_2400);
    update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    lookup(32'h0000_1000);
    pred("ctr1", 1'b0, 32'h0000_1004);

    // Same-edge bypass: hit path (ctr 1->2, new target) and allocate path
    idle();
    bus.lk_valid = 1'b1;  bus.lk_pc = 32'h0000_1000;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_1000;
    bus.upd_taken = 1'b1; bus.upd_target = 32'h0000_3000;
    step();
    pred("byp_hit", 1'b1, 32'h0000_3000);
    idle();
    bus.lk_valid = 1'b1;  bus.lk_pc = 32'h0000_1010;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_1010;
    bus.upd_taken = 1'b1; bus.upd_target = 32'h0000_5000;
    step();
    pred("byp_alloc", 1'b1, 32'h0000_5000);

    // Flush with a simultaneous allocating update and a lookup of a valid entry
    idle();
    bus.flush_all = 1'b1;
    bus.lk_valid = 1'b1;  bus.lk_pc = 32'h0000_1000;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_1100;
    bus.upd_taken = 1'b1; bus.upd_target = 32'h0000_6000;
    step();
    pred("flush_same", 1'b0, 32'h0000_1004);
    lookup(32'h0000_1000);
    pred("flush_after", 1'b0, 32'h0000_1004);
    lookup(32'h0000_1100);
    pred("flush_noalloc", 1'b0, 32'h0000_1104);
    lookup(32'h0000_1010);
    pred("flush_other", 1'b0, 32'h0000_1014);

    // Asynchronous reset between edges while a prediction is outstanding
    update(32'h0000_1000, 1'b1, 32'h0000_7000);
    lookup(32'h0000_1000);
    pred("pre_rst", 1'b1, 32'h0000_7000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid",  32'(bus.pred_valid), 32'd0);
    check("arst.taken",  32'(bus.pred_taken), 32'd0);
    check("arst.target", bus.pred_target, 32'd0);
    step();
    check("rst_hold.valid", 32'(bus.pred_valid), 32'd0);
    idle();
    rst_n = 1'b1;
    step();
    check("post_rst.valid", 32'(bus.pred_valid), 32'd0);
    lookup(32'h0000_1000);
    pred("post_rst_miss", 1'b0, 32'h0000_1004);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_btb_tagged.md
BP_BTB_TAGGED -- requirements
Module: bp_btb_tagged

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of direct-mapped entries (power of two, 4..1024).
REQ-002 SHALL have parameter TAG_W, default 8, number of tag bits stored per entry (1..20).
REQ-003 SHALL have parameter CTR_W, default 2, width of the per-entry saturating direction counter (1..4).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port lk_valid, input, 1, lookup request from IF1 this cycle.
REQ-007 SHALL have port lk_pc, input, 32, fetch PC to predict.
REQ-008 SHALL have port pred_valid, output, 1, registered prediction valid for the previous cycle's lookup.
REQ-009 SHALL have port pred_taken, output, 1, predict taken.
REQ-010 SHALL have port pred_target, output, 32, predicted next PC.
REQ-011 SHALL have port upd_valid, input, 1, resolved-branch update from EX.
REQ-012 SHALL have port upd_pc, input, 32, PC of the resolved branch.
REQ-013 SHALL have port upd_taken, input, 1, actual branch outcome.
REQ-014 SHALL have port upd_target, input, 32, actual taken target.
REQ-015 SHALL have port flush_all, input, 1, invalidate every entry.

Function
REQ-016 SHALL use index IDX_W=log2(ENTRIES) taken from pc[IDX_W+1:2], and tag from pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] is ignored.
REQ-017 SHALL give each entry: valid bit, TAG_W tag, 32-bit target, CTR_W counter.
REQ-018 SHALL give a lookup one-cycle latency: lk_valid sampled at edge N produces pred_valid=1 during cycle N+1; when lk_valid=0 at edge N, pred_valid=0 during cycle N+1.
REQ-019 SHALL treat a lookup as a hit when valid=1 and the stored tag equals the lookup tag.
REQ-020 SHALL drive pred_taken=1 only on a hit whose counter MSB=1.
REQ-021 SHALL drive pred_target=stored target when pred_taken=1, else lk_pc+4 (registered, mod 2^32).
REQ-022 SHALL, on an update that hits, increment the counter on taken and decrement on not-taken, saturating at 2^CTR_W-1 and 0.
REQ-023 SHALL, on an update that hits with upd_taken=1, overwrite the stored target with upd_target.
REQ-024 SHALL, on an update that misses with upd_taken=1, allocate the entry: valid=1, new tag, target=upd_target, counter=2^(CTR_W-1) (weakly taken), replacing any previous occupant.
REQ-025 SHALL leave the entry unchanged on an update that misses with upd_taken=0.
REQ-026 SHALL apply an update at the clock edge where upd_valid=1, so that it is visible to a lookup sampled at the following edge.
REQ-027 SHALL, when a lookup and an update address the same index at the same edge, bypass: the lookup result reflects the post-update entry.
REQ-028 SHALL clear all valid bits at the edge where flush_all=1; an update at that edge is discarded.
REQ-029 SHALL report a miss (pred_taken=0, pred_target=lk_pc+4) for a lookup sampled at the same edge as flush_all=1.

Reset
REQ-030 SHALL, while rst_n=0, force pred_valid=0, pred_taken=0, pred_target=0, all valid bits=0, and all counters=2^(CTR_W-1)-1 (weakly not-taken), independent of clk.
REQ-031 SHALL leave tags and targets unreset (storage may be RAM-inferred).
REQ-032 SHALL drop any in-flight lookup when reset asserts mid-operation; the first pred_valid=1 after reset deassertion is for a lookup sampled after deassertion.

Structure
REQ-033 SHALL place the default parameter values and the counter-encoding constants (weak-taken, weak-not-taken values) in the shared defs include alongside the existing BTB definitions.
REQ-034 SHALL implement counter update in one sub-module, bp_satctr (CTR_W parameter, in: ctr, taken; out: next ctr), instantiated for the update path and the bypass path.

Verification
REQ-035 SHALL pass: reset, then lookup 0x1000 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x1004.
REQ-036 SHALL pass: update pc=0x1000 taken target=0x2000, then lookup 0x1000 -> pred_taken=1, pred_target=0x2000; lookup 0x1000+4*64 (same index, different tag) -> miss, target=0x1104.
REQ-037 SHALL pass: with entry at counter 2, two not-taken updates then lookup -> pred_taken=0; three more not-taken -> counter stays 0; four taken -> counter saturates at 3.
REQ-038 SHALL pass: same-edge update (0x1000 taken, 0x3000) and lookup 0x1000 -> pred_target=0x3000 next cycle.
REQ-039 SHALL pass: flush_all with simultaneous update and lookup of a valid entry -> lookup misses, the following lookup misses, and the update did not allocate.
REQ-040 SHALL pass: rst_n pulsed low between clock edges while pred_valid=1 -> outputs zero immediately; all prior entries miss afterward.
